// File: rtl/seg7_scan.sv
// seg7_scan: six-digit common-anode 7-segment scan driver.
// Snapshots BCD digits per frame; registered glitch-free an/seg/dp.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-low reset
//   i_hr_10..i_sec_1    BCD digits 5..0 (i_sec_1 = digit 0)
//   i_blink_mask        per-digit blink enable (live)
//   i_dp_mask           per-digit decimal point (live)
//   o_an                digit enables, active-low
//   o_seg               segments {g,f,e,d,c,b,a}, active-low
//   o_dp                decimal point, active-low
// Build option: SEG7_LZ_BLANK_EN blanks digit 5 when hr_10 is 0.
module seg7_scan #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int BLINK_HZ = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_hr_10,
  input  logic [3:0] i_hr_1,
  input  logic [3:0] i_min_10,
  input  logic [3:0] i_min_1,
  input  logic [3:0] i_sec_10,
  input  logic [3:0] i_sec_1,
  input  logic [5:0] i_blink_mask,
  input  logic [5:0] i_dp_mask,
  output logic [5:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW   = $clog2(DIV);
  localparam int BW   = $clog2(BDIV + 1);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BDIV - 1);

  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic [2:0]    r_idx;
  logic [23:0]   r_snap;

  logic          w_tick;
  logic          w_wrap;
  logic [2:0]    w_nidx;
  logic [3:0]    w_digit;
  logic [6:0]    w_glyph;
  logic          w_blank;
  logic [6:0]    w_seg;
  logic          w_dp;
  logic [5:0]    w_an;

  assign w_tick = (r_presc == P_LAST);
  assign w_wrap = (r_idx == 3'd5);
  assign w_nidx = w_wrap ? 3'd0 : r_idx + 3'd1;

  // Digit 0 is loaded on the snapshot edge, so it reads the
  // live input, which is exactly what the snapshot captures.
  always_comb begin
    w_digit = i_sec_1;
    unique case (w_nidx)
      3'd1:    w_digit = r_snap[7:4];
      3'd2:    w_digit = r_snap[11:8];
      3'd3:    w_digit = r_snap[15:12];
      3'd4:    w_digit = r_snap[19:16];
      3'd5:    w_digit = r_snap[23:20];
      default: w_digit = i_sec_1;
    endcase
  end

  always_comb begin
    w_glyph = 7'h3F;
    unique case (w_digit)
      4'd0:    w_glyph = 7'h40;
      4'd1:    w_glyph = 7'h79;
      4'd2:    w_glyph = 7'h24;
      4'd3:    w_glyph = 7'h30;
      4'd4:    w_glyph = 7'h19;
      4'd5:    w_glyph = 7'h12;
      4'd6:    w_glyph = 7'h02;
      4'd7:    w_glyph = 7'h78;
      4'd8:    w_glyph = 7'h00;
      4'd9:    w_glyph = 7'h10;
      default: w_glyph = 7'h3F;
    endcase
  end

  // Phase is the pre-edge value: a toggle on this edge only
  // affects the next digit load.
  always_comb begin
    w_blank = r_phase & i_blink_mask[w_nidx];
    w_seg   = w_glyph;
    w_dp    = ~i_dp_mask[w_nidx];
`ifdef SEG7_LZ_BLANK_EN
    if (w_nidx == 3'd5 && w_digit == 4'd0)
      w_seg = 7'h7F;
`endif
    if (w_blank) begin
      w_seg = 7'h7F;
      w_dp  = 1'b1;
    end
    w_an = ~(6'b000001 << w_nidx);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_presc <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_idx   <= 3'd5;
      r_snap  <= '0;
      o_an    <= 6'h3F;
      o_seg   <= 7'h7F;
      o_dp    <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (r_bcnt == B_LAST) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
      if (w_tick) begin
        r_idx <= w_nidx;
        if (w_wrap)
          r_snap <= {i_hr_10, i_hr_1, i_min_10,
                     i_min_1, i_sec_10, i_sec_1};
        o_an  <= w_an;
        o_seg <= w_seg;
        o_dp  <= w_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed bench for seg7_scan.
// DIV=12, BDIV=60; t counts edges since reset release.
module tb_seg7_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] hr_10, hr_1, min_10, min_1, sec_10, sec_1;
  logic [5:0] blink_mask, dp_mask;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_run  = 0;
  int n_fail = 0;
  int t      = 0;

  logic [5:0] exp_an  [6];
  logic [6:0] exp_seg [6];
  logic [6:0] lz_seg;

  seg7_scan #(
    .CLK_HZ  (1200),
    .SCAN_HZ (100),
    .BLINK_HZ(10)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_hr_10     (hr_10),
    .i_hr_1      (hr_1),
    .i_min_10    (min_10),
    .i_min_1     (min_1),
    .i_sec_10    (sec_10),
    .i_sec_1     (sec_1),
    .i_blink_mask(blink_mask),
    .i_dp_mask   (dp_mask),
    .o_an        (an),
    .o_seg       (seg),
    .o_dp        (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic goto(input int target);
    while (t < target) step();
  endtask

  task automatic show(input string tag, input logic [5:0] a,
                      input logic [6:0] s, input logic d);
    check({tag, ".an"}, {26'd0, an}, {26'd0, a});
    check({tag, ".seg"}, {25'd0, seg}, {25'd0, s});
    check({tag, ".dp"}, {31'd0, dp}, {31'd0, d});
  endtask

  initial begin
    exp_an  = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    exp_seg = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
`ifdef SEG7_LZ_BLANK_EN
    lz_seg = 7'h7F;
`else
    lz_seg = 7'h40;
`endif
    rst_n = 1'b0;
    hr_10 = 4'd1; hr_1 = 4'd2; min_10 = 4'd3;
    min_1 = 4'd4; sec_10 = 4'd5; sec_1 = 4'd6;
    blink_mask = '0;
    dp_mask    = '0;
    repeat (3) step();
    show("reset", 6'h3F, 7'h7F, 1'b1);
    rst_n = 1'b1;
    t = 0;

    goto(11);
    show("pre_tick", 6'h3F, 7'h7F, 1'b1);

    for (int d = 0; d < 6; d++) begin
      goto(12 + 12 * d);
      show($sformatf("f1d%0d", d), exp_an[d], exp_seg[d], 1'b1);
      if (d == 3) sec_1 = 4'd9;
      goto(23 + 12 * d);
      check($sformatf("f1d%0d.hold", d),
            {26'd0, an}, {26'd0, exp_an[d]});
    end

    goto(84);
    show("f2d0_new", 6'h3E, 7'h10, 1'b1);

    blink_mask = 6'b000011;
    goto(96);
    show("blk_d1_ph1", 6'h3D, 7'h7F, 1'b1);
    goto(108);
    show("blk_d2", 6'h3B, 7'h19, 1'b1);
    goto(156);
    show("blk_d0_ph0", 6'h3E, 7'h10, 1'b1);
    goto(168);
    show("blk_d1_ph0", 6'h3D, 7'h12, 1'b1);
    goto(228);
    show("blk_d0_ph1", 6'h3E, 7'h7F, 1'b1);
    goto(240);
    show("blk_d1_edge", 6'h3D, 7'h7F, 1'b1);
    goto(252);
    show("blk_d2_ph0", 6'h3B, 7'h19, 1'b1);

    blink_mask = '0;
    sec_10  = 4'hC;
    dp_mask = 6'b000100;
    goto(300);
    show("dp_d0", 6'h3E, 7'h10, 1'b1);
    goto(312);
    show("dash_d1", 6'h3D, 7'h3F, 1'b1);
    goto(324);
    show("dp_d2", 6'h3B, 7'h19, 1'b0);
    goto(335);
    check("dp_d2_hold", {31'd0, dp}, 32'd0);
    goto(336);
    show("dp_d3", 6'h37, 7'h30, 1'b1);

    hr_10   = 4'd0;
    dp_mask = 6'b100100;
    goto(348);
    show("old_d4", 6'h2F, 7'h24, 1'b1);
    goto(360);
    show("old_d5", 6'h1F, 7'h79, 1'b0);
    goto(432);
    show("lz_d5", 6'h1F, lz_seg, 1'b0);

    goto(480);
    check("pre_rst_an", {26'd0, an}, 32'h37);
    rst_n = 1'b0;
    step();
    show("mid_rst", 6'h3F, 7'h7F, 1'b1);
    rst_n = 1'b1;
    t = 0;
    goto(11);
    check("rst_hold_an", {26'd0, an}, 32'h3F);
    goto(12);
    show("rst_d0", 6'h3E, 7'h10, 1'b0 ^ 1'b1);
    goto(24);
    show("rst_d1", 6'h3D, 7'h3F, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Display back-end for the clock and countdown datapath. Consumes six BCD digits (hours/minutes/seconds, tens and units) plus cursor-blink and decimal-point masks. Drives a six-digit, common-anode, time-multiplexed 7-segment display with registered, glitch-free outputs. Sits directly downstream of the countdown/time-set blocks on the board's 50 MHz clock.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz
- SCAN_HZ, 1_000, per-digit scan rate in Hz; DIV = CLK_HZ/SCAN_HZ, must be an integer ≥ 2
- BLINK_HZ, 2, blink rate in Hz; BDIV = CLK_HZ/(2*BLINK_HZ), must be an integer ≥ 1
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset
- hr_10, hr_1, min_10, min_1, sec_10, sec_1  in  4 each  BCD digits 5..0 (sec_1 = digit 0, rightmost)
- blink_mask  in  6  bit i set: digit i blinks (edit cursor)
- dp_mask  in  6  bit i set: decimal point lit on digit i
- an  out  6  digit enables, active-low; an[i] drives digit i
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation
- Prescaler counts 0..DIV-1 and wraps. tick = (prescaler == DIV-1).
- Digit index idx runs 0..5. On a tick, idx advances; 5 wraps to 0.
- Frame snapshot: on the tick where idx goes 5→0, all six digit inputs are captured into a snapshot register.
  - Digit 0 in that same edge's output load uses the live inputs, which equal the captured values.
  - Digit inputs changed mid-frame do not appear until the next frame (no tearing).
- blink_mask and dp_mask are sampled live at each digit load, not snapshotted.
- Blink phase bit toggles every BDIV cycles from a free-running counter that is independent of the scan.
- Decode, active-low hex values: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10. Values A–F show a dash (3F).
- Blanking: when blink phase = 1 and blink_mask[idx] = 1, seg = 7F and dp = 1. an still selects the digit.
- dp = ~dp_mask[idx] unless the digit is blanked.
- Exactly one an bit is low at any time after the first tick. an is never all-low.

## Timing
- Reset values (first edge with reset = 0):
  - an = 6'h3F, seg = 7'h7F, dp = 1
  - prescaler = 0, idx = 5, blink counter = 0, blink phase = 0, snapshot = 0
- All outputs are registered and change only on the tick edge, together with idx.
- First tick occurs DIV cycles after reset deassertion. It wraps idx to 0, takes the snapshot, and sets an = 6'h3E.
- Each digit is displayed for exactly DIV cycles. A frame is 6·DIV cycles.
- Reset asserted mid-frame wins over tick: all state returns to reset values on that edge.
- Blink and scan ticks on the same edge are independent.
  - A phase toggle affects blanking from the next digit load, not the currently displayed digit.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking. When snapshot hr_10 == 0, digit 5 shows seg = 7F, and dp still follows dp_mask[5].
- Undefined: hr_10 == 0 displays "0" (seg = 40).

## Test plan
All tests use CLK_HZ=1200, SCAN_HZ=100 (DIV=12), BLINK_HZ=10 (BDIV=60).
- Reset low 3 cycles, then release → an=3F, seg=7F, dp=1 for 12 cycles. On cycle 12, an=3E.
- Digits hr..sec = 1,2,3,4,5,6 with masks 0 → over one frame:
  - an = 3E, 3D, 3B, 37, 2F, 1F
  - seg = 02, 12, 19, 30, 24, 79
  - each held 12 cycles
- At idx=3, change sec_1 from 6 to 9 → current frame unchanged. Next frame digit 0 shows seg=10.
- blink_mask=6'b000011 → digits 0 and 1 show seg=7F in loads during phase 1 (phase toggles every 60 cycles) and normal glyphs in phase 0. Digits 2–5 are unaffected.
- sec_10=4'hC and dp_mask=6'b000100 → digit 1 shows seg=3F. dp=0 only while an=3B.
- hr_10=0 → digit 5 shows seg=7F with SEG7_LZ_BLANK_EN, and 40 without. Assert reset at idx=3 → next edge returns an=3F, and the following scan restarts at digit 0.
